board_lock_clear: RTL
=====================

Name: board_lock_clear

Overview:
- Downstream stage of the falling-block generator/mover.
- When the active piece lands (bottom_flag), it writes the piece's four cells into the 10x12 playfield.
- It then scans and collapses full rows, counts cleared lines, and requests the next piece with a one-cycle gen_flag pulse.
- It drives the arr0..arr11 occupancy rows back to the mover for collision checks, and handles game-over via top_flag/Ack.

Parameters:
- LINES_W, 8: width of the cleared-lines counter. The counter saturates at 2^LINES_W-1.

Ports:
- Clk  in  1  system clock; all state changes on posedge.
- Reset  in  1  asynchronous, active-low reset (Reset=0 resets the block).
- x1,y1,x2,y2,x3,y3,x4,y4  in  4 each  landed piece cell coordinates; x = column 0..9, y = row 0..11, row 0 is the bottom.
- bottom_flag  in  1  level; high while the mover waits with a landed piece.
- top_flag  in  1  level; landed piece touches row 11 (game over).
- Ack  in  1  user acknowledge; restarts after game over.
- arr0..arr11  out  10 each  row r occupancy; bit i = column i; registered.
- gen_flag  out  1  one-cycle pulse requesting a new piece.
- game_over  out  1  high in the OVER state.
- lines  out  LINES_W  total rows cleared since reset or restart.
- busy  out  1  high in LOCK, SCAN or CLEAR.
- state  out  3  one-hot-free encoded state, for debug.

Behaviour:
- Reset (Reset=0, asynchronous):
  - all arr rows = 0, gen_flag=0, game_over=0, lines=0, row pointer=0, state=START.
  - Reset asserted mid-operation aborts immediately to these values.
- START: gen_flag=1 for exactly this one cycle; next state RELEASE.
- RELEASE: wait for bottom_flag=0, then go to IDLE. This prevents relocking the same piece while the mover still holds bottom_flag.
- IDLE: when bottom_flag=1, capture x1..y4 and go to LOCK.
- LOCK (1 cycle):
  - set arr[y_k][x_k]=1 for k=1..4.
  - cells with x>9 or y>11 are ignored.
  - duplicate coordinates are harmless.
  - set row pointer r=0; go to SCAN.
- SCAN (one row per cycle):
  - if row r == 10'h3FF: row j <= row j+1 for j=r..10, row 11 <= 0, lines <= lines+1 (saturating); r is not advanced, so the shifted-in row is rechecked next cycle.
  - else r <= r+1.
  - when r reaches 12, go to DONE.
  - SCAN latency = 12 + k cycles, where k = rows cleared.
- DONE (1 cycle):
  - if top_flag=1 (sampled this cycle), go to OVER with no gen_flag.
  - else gen_flag=1 this cycle, then RELEASE.
- OVER: game_over=1 and the board is frozen. On Ack=1, go to CLEAR.
- CLEAR (1 cycle): all rows = 0, lines = 0; next state START, which issues the restart gen_flag pulse.
- Inputs ignored outside their states:
  - bottom_flag outside IDLE.
  - Ack outside OVER.
  - x/y changes after capture.
- Cycle budget per landing: LOCK (1) + SCAN (12+k) + DONE (1) = 14+k cycles from the IDLE capture edge to the gen_flag pulse.
- arr outputs change only in LOCK, SCAN (on a clear) and CLEAR. Intermediate SCAN values are visible to the mover, which is parked in its wait state.

Test Plan:
- Reset deassert -> gen_flag high exactly 1 cycle in START; arr0..arr11=0, lines=0, game_over=0.
- Lock a horizontal line, cells (4,0),(5,0),(6,0),(7,0), bottom_flag=1 -> arr0=10'h0F0. gen_flag pulses 14 cycles after the capture edge. Holding bottom_flag high 10 more cycles causes no relock and no second pulse.
- Single clear: build row0=10'h3F0 and row1=10'h003, then lock (0,0),(1,0),(2,0),(3,0) -> arr0=10'h003, arr1=0, lines=1; gen_flag 15 cycles after capture.
- Double clear: rows 0 and 1 full after a lock, row2=10'h200 -> arr0=10'h200, arr1=arr2=0, lines=2; latency 16 cycles.
- Game over: lock with top_flag=1 -> game_over=1 and no gen_flag. Ack=1 for 1 cycle -> CLEAR, then all rows 0, lines 0, one gen_flag pulse, game_over=0.
- Reset pulled low mid-SCAN with a full row pending -> all rows 0, lines 0 immediately. After release, START gen_flag pulse.

Source files
------------

// File: rtl/board_lock_clear_if.sv
// Playfield lock/clear bus: landed-piece coordinates and flags in, occupancy rows and status out.
interface board_lock_clear_if #(parameter int LINES_W = 8);
    logic [3:0]         x1, y1, x2, y2, x3, y3, x4, y4;
    logic               bottom_flag;
    logic               top_flag;
    logic               Ack;
    logic [9:0]         arr0, arr1, arr2, arr3, arr4, arr5;
    logic [9:0]         arr6, arr7, arr8, arr9, arr10, arr11;
    logic               gen_flag;
    logic               game_over;
    logic [LINES_W-1:0] lines;
    logic               busy;
    logic [2:0]         state;

    modport master (
        output x1, y1, x2, y2, x3, y3, x4, y4, bottom_flag, top_flag, Ack,
        input  arr0, arr1, arr2, arr3, arr4, arr5, arr6, arr7, arr8, arr9, arr10, arr11,
        input  gen_flag, game_over, lines, busy, state
    );

    modport slave (
        input  x1, y1, x2, y2, x3, y3, x4, y4, bottom_flag, top_flag, Ack,
        output arr0, arr1, arr2, arr3, arr4, arr5, arr6, arr7, arr8, arr9, arr10, arr11,
        output gen_flag, game_over, lines, busy, state
    );
endinterface

// File: rtl/board_lock_clear.sv
// Locks a landed piece into the 10x12 playfield, collapses full rows, counts lines and requests the next piece.
module board_lock_clear #(
    parameter int LINES_W = 8
) (
    input logic               Clk,
    input logic               Reset,
    board_lock_clear_if.slave bus
);

    typedef enum logic [2:0] {
        S_START   = 3'd0,
        S_RELEASE = 3'd1,
        S_IDLE    = 3'd2,
        S_LOCK    = 3'd3,
        S_SCAN    = 3'd4,
        S_DONE    = 3'd5,
        S_OVER    = 3'd6,
        S_CLEAR   = 3'd7
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [9:0]         r_arr  [0:11];
    logic [9:0]         w_mask [0:11];
    logic [3:0]         r_x    [0:3];
    logic [3:0]         r_y    [0:3];
    logic [3:0]         w_x    [0:3];
    logic [3:0]         w_y    [0:3];
    logic [3:0]         r_ptr;
    logic [LINES_W-1:0] r_lines;
    logic [9:0]         w_cur_row;
    logic               w_row_full;

    assign w_x[0] = bus.x1;
    assign w_y[0] = bus.y1;
    assign w_x[1] = bus.x2;
    assign w_y[1] = bus.y2;
    assign w_x[2] = bus.x3;
    assign w_y[2] = bus.y3;
    assign w_x[3] = bus.x4;
    assign w_y[3] = bus.y4;

    assign w_cur_row  = (r_ptr < 4'd12) ? r_arr[r_ptr] : '0;
    assign w_row_full = (w_cur_row == '1);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_START;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_START:   w_next = S_RELEASE;
            S_RELEASE: if (!bus.bottom_flag) w_next = S_IDLE;
            S_IDLE:    if (bus.bottom_flag) w_next = S_LOCK;
            S_LOCK:    w_next = S_SCAN;
            // A cleared row keeps the pointer in place, so only a non-full last row ends the scan.
            S_SCAN:    if (!w_row_full && (r_ptr == 4'd11)) w_next = S_DONE;
            S_DONE:    w_next = bus.top_flag ? S_OVER : S_RELEASE;
            S_OVER:    if (bus.Ack) w_next = S_CLEAR;
            S_CLEAR:   w_next = S_START;
            default:   w_next = S_START;
        endcase
    end

    always_comb begin
        for (int unsigned r = 0; r < 12; r++) begin
            w_mask[r] = '0;
        end
        for (int unsigned k = 0; k < 4; k++) begin
            if ((r_x[k] < 4'd10) && (r_y[k] < 4'd12)) begin
                w_mask[r_y[k]][r_x[k]] = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int unsigned r = 0; r < 12; r++) begin
                r_arr[r] <= '0;
            end
            for (int unsigned k = 0; k < 4; k++) begin
                r_x[k] <= '0;
                r_y[k] <= '0;
            end
            r_ptr   <= '0;
            r_lines <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.bottom_flag) begin
                        for (int unsigned k = 0; k < 4; k++) begin
                            r_x[k] <= w_x[k];
                            r_y[k] <= w_y[k];
                        end
                    end
                end
                S_LOCK: begin
                    for (int unsigned r = 0; r < 12; r++) begin
                        r_arr[r] <= r_arr[r] | w_mask[r];
                    end
                    r_ptr <= '0;
                end
                S_SCAN: begin
                    if (w_row_full) begin
                        for (int unsigned r = 0; r < 11; r++) begin
                            if (r >= 32'(r_ptr)) begin
                                r_arr[r] <= r_arr[r+1];
                            end
                        end
                        r_arr[11] <= '0;
                        if (r_lines != '1) begin
                            r_lines <= r_lines + 1'b1;
                        end
                    end else begin
                        r_ptr <= r_ptr + 4'd1;
                    end
                end
                S_CLEAR: begin
                    for (int unsigned r = 0; r < 12; r++) begin
                        r_arr[r] <= '0;
                    end
                    r_lines <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.arr0  = r_arr[0];
    assign bus.arr1  = r_arr[1];
    assign bus.arr2  = r_arr[2];
    assign bus.arr3  = r_arr[3];
    assign bus.arr4  = r_arr[4];
    assign bus.arr5  = r_arr[5];
    assign bus.arr6  = r_arr[6];
    assign bus.arr7  = r_arr[7];
    assign bus.arr8  = r_arr[8];
    assign bus.arr9  = r_arr[9];
    assign bus.arr10 = r_arr[10];
    assign bus.arr11 = r_arr[11];

    // The reset state is START, so the request pulse is masked while Reset is held low.
    assign bus.gen_flag  = Reset && ((r_state == S_START) ||
                                     ((r_state == S_DONE) && !bus.top_flag));
    assign bus.game_over = (r_state == S_OVER);
    assign bus.busy      = (r_state == S_LOCK) || (r_state == S_SCAN) || (r_state == S_CLEAR);
    assign bus.lines     = r_lines;
    assign bus.state     = r_state;

endmodule
